// File: rtl/util_io_test_mc_if.sv
// Register-bank and pad-side signals of the IO loopback tester.
// master = register bank / pad harness, slave = tester core.
interface util_io_test_mc_if #(
  parameter int unsigned IN_WIDTH      = 32,
  parameter int unsigned OUT_WIDTH     = 32,
  parameter int unsigned ERR_CNT_WIDTH = 16
);
  logic                              en;
  logic                              clr;
  logic                              mode;
  logic                              baud_load;
  logic [31:0]                       baud_div;
  logic [OUT_WIDTH-1:0]              io_default;
  logic [OUT_WIDTH-1:0]              force_default;
  logic [OUT_WIDTH-1:0]              io_o;
  logic [IN_WIDTH-1:0]               io_i;
  logic [IN_WIDTH-1:0]               io_i_r;
  logic [IN_WIDTH-1:0]               state;
  logic                              state_valid;
  logic [IN_WIDTH*ERR_CNT_WIDTH-1:0] err_cnt;
  logic [31:0]                       win_cnt;

  modport master (
    output en, clr, mode, baud_load, baud_div, io_default, force_default, io_i,
    input  io_o, io_i_r, state, state_valid, err_cnt, win_cnt
  );

  modport slave (
    input  en, clr, mode, baud_load, baud_div, io_default, force_default, io_i,
    output io_o, io_i_r, state, state_valid, err_cnt, win_cnt
  );
endinterface

// File: rtl/util_io_test_mc.sv
// IO loopback tester: toggles outputs on divider ticks and checks looped-back inputs
// per window in toggle or stuck-at mode, with sticky flags and saturating counters.
module util_io_test_mc #(
  parameter int unsigned IN_WIDTH      = 32,
  parameter int unsigned OUT_WIDTH     = 32,
  parameter int unsigned WIN_LEN       = 8,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input logic              clk,
  input logic              rstn,
  util_io_test_mc_if.slave bus
);
  localparam int unsigned SCW = $clog2(WIN_LEN);
  localparam logic [SCW-1:0] LastSample = SCW'(WIN_LEN - 1);

  function automatic logic [WIN_LEN-1:0] alt_pattern();
    logic [WIN_LEN-1:0] p;
    for (int k = 0; k < WIN_LEN; k++) p[k] = ((k % 2) == 0);
    return p;
  endfunction

  localparam logic [WIN_LEN-1:0] AltPat = alt_pattern();

  logic [31:0]                                r_div;
  logic [31:0]                                r_cnt;
  logic                                       r_tick;
  logic                                       r_mode;
  logic [OUT_WIDTH-1:0]                       r_io_o;
  logic [WIN_LEN-1:0]                         r_shift [IN_WIDTH];
  logic [SCW-1:0]                             r_sample_cnt;
  logic                                       r_win_done;
  logic                                       r_first_win;
  logic [IN_WIDTH-1:0]                        r_state;
  logic                                       r_state_valid;
  logic [IN_WIDTH-1:0][ERR_CNT_WIDTH-1:0]     r_err_cnt;
  logic [31:0]                                r_win_cnt;
  logic [IN_WIDTH-1:0]                        w_fail;
  logic [IN_WIDTH-1:0]                        w_io_i_r;

  always_comb begin
    w_fail   = '0;
    w_io_i_r = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_io_i_r[i] = r_shift[i][0];
      if (r_mode) w_fail[i] = (r_shift[i] == '0) || (r_shift[i] == '1);
      else        w_fail[i] = (r_shift[i] != AltPat) && (r_shift[i] != ~AltPat);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_div         <= 32'd1;
      r_cnt         <= '0;
      r_tick        <= 1'b0;
      r_mode        <= 1'b0;
      r_io_o        <= bus.io_default;
      for (int i = 0; i < IN_WIDTH; i++) r_shift[i] <= '0;
      r_sample_cnt  <= '0;
      r_win_done    <= 1'b0;
      r_first_win   <= 1'b1;
      r_state       <= '0;
      r_state_valid <= 1'b0;
      r_err_cnt     <= '0;
      r_win_cnt     <= '0;
    end else begin
      if (bus.baud_load) r_div <= bus.baud_div;
      if (!bus.en) r_mode <= bus.mode;
      for (int i = 0; i < OUT_WIDTH; i++) begin
        if (!bus.en || bus.force_default[i]) r_io_o[i] <= bus.io_default[i];
        else if (r_tick)                     r_io_o[i] <= ~r_io_o[i];
      end
      r_state_valid <= 1'b0;
      if (!bus.en) begin
        r_cnt        <= '0;
        r_tick       <= 1'b0;
        for (int i = 0; i < IN_WIDTH; i++) r_shift[i] <= '0;
        r_sample_cnt <= '0;
        r_win_done   <= 1'b0;
        r_first_win  <= 1'b1;
      end else begin
        // Compare against div-1 so a huge divisor never needs a cnt+1 overflow check.
        if (r_div == '0) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
        end else if (r_cnt == r_div - 32'd1) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + 32'd1;
          r_tick <= 1'b0;
        end
        r_win_done <= 1'b0;
        if (r_tick) begin
          for (int i = 0; i < IN_WIDTH; i++) r_shift[i] <= {r_shift[i][WIN_LEN-2:0], bus.io_i[i]};
          if (r_sample_cnt == LastSample) begin
            r_sample_cnt <= '0;
            r_win_done   <= 1'b1;
          end else begin
            r_sample_cnt <= r_sample_cnt + SCW'(1);
          end
        end
        // First window after enable only warms up the pipeline and is dropped.
        if (r_win_done) begin
          if (r_first_win) begin
            r_first_win <= 1'b0;
          end else begin
            r_state_valid <= 1'b1;
            if (!bus.clr) begin
              r_state <= r_state | w_fail;
              for (int i = 0; i < IN_WIDTH; i++) begin
                if (w_fail[i] && (r_err_cnt[i] != '1)) begin
                  r_err_cnt[i] <= r_err_cnt[i] + ERR_CNT_WIDTH'(1);
                end
              end
              if (r_win_cnt != '1) r_win_cnt <= r_win_cnt + 32'd1;
            end
          end
        end
      end
      if (bus.clr) begin
        r_state   <= '0;
        r_err_cnt <= '0;
        r_win_cnt <= '0;
      end
    end
  end

  assign bus.io_o        = r_io_o;
  assign bus.io_i_r      = w_io_i_r;
  assign bus.state       = r_state;
  assign bus.state_valid = r_state_valid;
  assign bus.err_cnt     = r_err_cnt;
  assign bus.win_cnt     = r_win_cnt;
endmodule

// File: tb/tb_util_io_test_mc.sv
// Bench for util_io_test_mc: directed phases with random data, checked every cycle
// against a window-level reference model.
module tb_util_io_test_mc;
  localparam int unsigned IW   = 8;
  localparam int unsigned OW   = 8;
  localparam int unsigned WL   = 8;
  localparam int unsigned EW   = 4;
  localparam int unsigned EMAX = (1 << EW) - 1;
  localparam logic [OW-1:0] DefLvl = 8'hA5;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  util_io_test_mc_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .ERR_CNT_WIDTH(EW)) bus ();

  util_io_test_mc #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .WIN_LEN(WL), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int unsigned   m_div, m_e;
  bit            m_mode, m_first, m_pend, m_sv;
  logic [IW-1:0] m_q[$];
  logic [IW-1:0] m_ready[WL];
  logic [IW-1:0] m_state, m_io_i_r;
  logic [OW-1:0] m_io_o;
  int unsigned   m_err[IW];
  logic [31:0]   m_win;

  // Stimulus knobs
  bit            lb_rand;
  logic [IW-1:0] stuck0, stuck1, glitch;
  int            glitch_n;
  bit            clr_on_eval, clr_fired;
  int            clr_hits;
  int            n_pulse, first_pulse, edge_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_div = 1; m_e = 0; m_mode = 0; m_first = 1; m_pend = 0; m_sv = 0;
    m_q.delete();
    m_state = '0; m_io_i_r = '0; m_io_o = bus.io_default; m_win = '0;
    foreach (m_err[c]) m_err[c] = 0;
  endtask

  // Toggle passes when every adjacent sample pair differs; stuck fails when all are equal.
  task automatic model_eval();
    for (int c = 0; c < IW; c++) begin
      int eq;
      bit f;
      eq = 0;
      for (int k = 1; k < WL; k++) if (m_ready[k][c] == m_ready[k-1][c]) eq++;
      f = m_mode ? (eq == WL - 1) : (eq != 0);
      if (f) begin
        m_state[c] = 1'b1;
        if (m_err[c] < EMAX) m_err[c]++;
      end
    end
    if (m_win != 32'hFFFF_FFFF) m_win++;
  endtask

  task automatic model_edge();
    bit samp;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_sv = 0;
    samp = 0;
    if (!bus.en) begin
      m_e = 0; m_q.delete(); m_pend = 0; m_first = 1; m_io_i_r = '0; m_mode = bus.mode;
    end else begin
      m_e++;
      samp = (m_div != 0) && (m_e > m_div) && (((m_e - 1) % m_div) == 0);
      if (m_pend) begin
        if (m_first) m_first = 0;
        else begin
          m_sv = 1;
          if (!bus.clr) model_eval();
        end
      end
      m_pend = 0;
      if (samp) begin
        m_q.push_back(bus.io_i);
        m_io_i_r = bus.io_i;
        if (m_q.size() == WL) begin
          for (int k = 0; k < WL; k++) m_ready[k] = m_q[k];
          m_q.delete();
          m_pend = 1;
        end
      end
    end
    for (int b = 0; b < OW; b++) begin
      if (!bus.en || bus.force_default[b]) m_io_o[b] = bus.io_default[b];
      else if (samp)                       m_io_o[b] = ~m_io_o[b];
    end
    if (bus.clr) begin
      m_state = '0; m_win = '0;
      foreach (m_err[c]) m_err[c] = 0;
    end
    if (bus.baud_load) m_div = bus.baud_div;
  endtask

  task automatic check_all();
    logic [IW*EW-1:0] e;
    for (int c = 0; c < IW; c++) e[c*EW +: EW] = EW'(m_err[c]);
    chk("io_o", bus.io_o, m_io_o);
    chk("io_i_r", bus.io_i_r, m_io_i_r);
    chk("state", bus.state, m_state);
    chk("state_valid", bus.state_valid, m_sv);
    chk("err_cnt", bus.err_cnt, e);
    chk("win_cnt", bus.win_cnt, m_win);
  endtask

  task automatic cyc(input int n);
    for (int j = 0; j < n; j++) begin
      logic [IW-1:0] v;
      @(negedge clk);
      v = lb_rand ? IW'($urandom) : bus.io_o;
      v = (v & ~stuck0) | stuck1;
      if (glitch_n > 0) begin
        v ^= glitch;
        glitch_n--;
      end
      bus.io_i = v;
      if (clr_on_eval && m_pend && !m_first && bus.en) begin
        bus.clr = 1'b1; clr_fired = 1; clr_on_eval = 0;
      end
      @(posedge clk);
      model_edge();
      #1;
      edge_idx++;
      if (bus.state_valid === 1'b1) begin
        n_pulse++;
        if (first_pulse < 0) first_pulse = edge_idx;
      end
      check_all();
      if (clr_fired) begin
        chk("clr_pulse", bus.state_valid, 1'b1);
        chk("clr_state", bus.state, '0);
        chk("clr_err", bus.err_cnt, '0);
        chk("clr_win", bus.win_cnt, '0);
        bus.clr = 1'b0; clr_fired = 0; clr_hits++;
      end
    end
  endtask

  task automatic phase_start();
    n_pulse = 0; first_pulse = -1; edge_idx = 0;
  endtask

  initial begin
    bus.en = 0; bus.clr = 0; bus.mode = 0; bus.baud_load = 0; bus.baud_div = '0;
    bus.io_default = DefLvl; bus.force_default = '0; bus.io_i = '0;
    lb_rand = 0; stuck0 = '0; stuck1 = '0; glitch = '0; glitch_n = 0;
    clr_on_eval = 0; clr_fired = 0; clr_hits = 0;
    phase_start();

    // Asynchronous reset before any clock edge
    #2 rstn = 1'b0;
    #1;
    chk("rst_io_o", bus.io_o, DefLvl);
    chk("rst_state", bus.state, '0);
    chk("rst_err", bus.err_cnt, '0);
    chk("rst_win", bus.win_cnt, '0);
    chk("rst_sv", bus.state_valid, 1'b0);
    model_reset();
    cyc(3);
    rstn = 1'b1;
    cyc(2);

    // Toggle mode, loopback, divider 4
    bus.baud_load = 1; bus.baud_div = 32'd4;
    cyc(1);
    bus.baud_load = 0;
    bus.en = 1;
    phase_start();
    cyc(400);
    chk("div4_pulses", n_pulse, 11);
    chk("div4_first", first_pulse, 66);
    chk("div4_state", bus.state, '0);

    // Channel 3 stuck low
    stuck0 = 8'h08;
    cyc(200);
    chk("stuck3_flag", bus.state[3], 1'b1);
    stuck0 = '0;
    bus.clr = 1;
    cyc(1);
    bus.clr = 0;

    // Single-sample glitch on channel 5 stays sticky
    cyc(20 + int'($urandom_range(0, 20)));
    glitch = 8'h20; glitch_n = 4;
    cyc(140);
    chk("glitch5_flag", bus.state[5], 1'b1);

    // Stuck-at mode with channel 0 alternately held high
    bus.en = 0; bus.mode = 1;
    cyc(2);
    bus.en = 1; lb_rand = 1;
    for (int blk = 0; blk < 4; blk++) begin
      stuck1 = (blk % 2) ? 8'h01 : 8'h00;
      cyc(64);
    end
    stuck1 = '0;
    bus.mode = 0;
    cyc(64);

    // Divider 0: frozen outputs, no windows
    bus.en = 0; bus.baud_load = 1; bus.baud_div = '0;
    cyc(1);
    bus.baud_load = 0;
    cyc(1);
    bus.en = 1; lb_rand = 0;
    phase_start();
    cyc(50);
    chk("div0_io_o", bus.io_o, DefLvl);
    chk("div0_pulses", n_pulse, 0);

    // Divider 1 with random forced bits
    bus.en = 0; bus.baud_load = 1; bus.baud_div = 32'd1;
    cyc(1);
    bus.baud_load = 0;
    bus.force_default = OW'($urandom);
    bus.en = 1;
    phase_start();
    cyc(100);
    chk("div1_pulses", n_pulse, 11);
    chk("div1_first", first_pulse, 18);
    bus.force_default = '0;

    // Error counter saturation
    stuck0 = 8'h01;
    cyc(200);
    chk("err0_sat", bus.err_cnt[EW-1:0], EMAX);
    stuck0 = '0;

    // clr coinciding with an evaluation
    clr_on_eval = 1;
    cyc(40);
    chk("clr_hit", clr_hits, 1);

    // Asynchronous reset mid-window
    stuck0 = 8'h10;
    cyc(13);
    #2 rstn = 1'b0;
    #1;
    chk("arst_io_o", bus.io_o, DefLvl);
    chk("arst_state", bus.state, '0);
    chk("arst_err", bus.err_cnt, '0);
    chk("arst_win", bus.win_cnt, '0);
    chk("arst_sv", bus.state_valid, 1'b0);
    model_reset();
    stuck0 = '0;
    cyc(2);
    rstn = 1'b1;
    cyc(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
